xbar_cfg_loader: RTL



---
 rtl/xbar_cfg_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/xbar_cfg_loader.sv
// Scan-chain configuration loader for a string of shift-register crossbar muxes.
// Host words arrive over valid/ready and are shifted LSB-first onto SE/SIN for
// exactly CHAIN_LEN cycles. Bits returning on SOUT are repacked into readback
// words so the host can verify the configuration being replaced.
module xbar_cfg_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [WORD_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              SE,
  output logic              SIN,
  input  logic              SOUT,
  output logic [WORD_W-1:0] RB_DATA,
  output logic              RB_VALID,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int IW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WLW = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] LEN_M1  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IW-1:0]    RB_LAST = IW'(WORD_W - 1);
  localparam logic [WLW-1:0]   WL_FULL = WLW'(WORD_W);
  localparam logic [WLW-1:0]   WL_ONE  = WLW'(1);

  logic [1:0]        state;
  logic [WORD_W-1:0] shreg;     // outgoing word, bit 0 is on SIN
  logic [WLW-1:0]    wleft;     // bits of the current word not yet shifted
  logic [CNT_W-1:0]  bitcnt;    // SE-high cycles so far in this load
  logic [WORD_W-1:0] rbreg;     // readback word being assembled
  logic [IW-1:0]     rbidx;     // next readback bit position
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              sin_hold;  // SIN value parked while SE is low

  logic              last;
  logic              word_end;
  logic              accept;
  logic [WORD_W-1:0] rb_next;

  // Handshake and readback-merge decode; ready also opens on the final bit of
  // a word so continuous input produces an unbroken SE run.
  always_comb begin
    last      = (bitcnt == LEN_M1);
    word_end  = (wleft == WL_ONE);
    DIN_READY = (state == S_WAIT) ||
                ((state == S_SHIFT) && word_end && !last);
    accept    = DIN_VALID && DIN_READY;
    rb_next   = rbreg;
    rb_next[rbidx] = SOUT;
  end

  assign SE       = (state == S_SHIFT);
  assign SIN      = (state == S_SHIFT) ? shreg[0] : sin_hold;
  assign BUSY     = (state != S_IDLE);
  assign DONE     = (state == S_FINISH);
  assign RB_DATA  = rb_data;
  assign RB_VALID = rb_valid;

  // Load sequencer: word acceptance, shifting, bit counting and readback capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      shreg    <= '0;
      wleft    <= '0;
      bitcnt   <= '0;
      rbreg    <= '0;
      rbidx    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
      sin_hold <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state  <= S_WAIT;
            bitcnt <= '0;
            rbidx  <= '0;
            rbreg  <= '0;
          end
        end
        S_WAIT: begin
          if (accept) begin
            shreg <= DIN;
            wleft <= WL_FULL;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sin_hold <= shreg[0];
          bitcnt   <= bitcnt + CNT_W'(1);
          // a full word, or whatever is left at the end of the chain, is emitted
          if ((rbidx == RB_LAST) || last) begin
            rb_data  <= rb_next;
            rb_valid <= 1'b1;
            rbidx    <= '0;
            rbreg    <= '0;
          end else begin
            rbreg <= rb_next;
            rbidx <= rbidx + IW'(1);
          end
          if (last) begin
            // upper bits of a word overhanging the chain end are dropped
            state <= S_FINISH;
            wleft <= '0;
          end else if (word_end) begin
            if (accept) begin
              shreg <= DIN;
              wleft <= WL_FULL;
            end else begin
              shreg <= shreg >> 1;
              wleft <= '0;
              state <= S_WAIT;
            end
          end else begin
            shreg <= shreg >> 1;
            wleft <= wleft - WLW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
